writeback_buffer: RTL and testbench
===================================

# writeback_buffer

Small in-order FIFO that collects 64-bit results from the execution units and drains them one per cycle into the architectural register file's write port. That port drives the `d`/`enable` inputs of the per-register 64-bit enable registers. It also provides a combinational forwarding lookup, so operand reads can see results that are buffered but not yet written. It sits between the execute/complete stage and the register file.

## Interface
Parameters:
- DEPTH, 4, number of buffer entries (power of two, ≥2)
- TAG_W, 5, destination register index width
- DATA_W, 64, result data width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserting low clears all state immediately
- flush  in  1  synchronous clear of all buffered entries
- in_valid  in  1  producer has a result
- in_ready  out  1  buffer can accept a result this cycle
- in_tag  in  TAG_W  destination register index
- in_data  in  DATA_W  result value
- wr_stall  in  1  register file cannot accept a write this cycle
- wr_en  out  1  write strobe to register file (drives `enable` of the selected register)
- wr_addr  out  TAG_W  register index to write
- wr_data  out  DATA_W  value to write (drives `d`)
- fwd_tag  in  TAG_W  operand register being read
- fwd_hit  out  1  a buffered entry targets fwd_tag
- fwd_data  out  DATA_W  youngest buffered value for fwd_tag
- count  out  $clog2(DEPTH)+1  number of valid entries

## Operation
- Storage: circular array of {tag, data}. Head and tail pointers carry an extra wrap bit.
  - empty = (head == tail)
  - full = indices equal and wrap bits differ
- Push: occurs when in_valid && in_ready. Writes the entry at tail; tail advances.
- Zero register: in_tag == ZERO_REG (31) is accepted (handshake completes) but not stored; tail and count are unchanged.
- in_ready = !full && !flush && reset deasserted. There is no combinational path from wr_stall to in_ready.
- Drain:
  - wr_en = !empty && !wr_stall && !flush
  - wr_addr and wr_data show the head entry whenever !empty, and are 0 when empty.
  - Head advances in any cycle where wr_en = 1.
- Simultaneous push and drain: both take effect and count is unchanged. When the buffer is full, a push is refused even if a drain happens that cycle.
- Forwarding (combinational):
  - fwd_hit = 1 if any valid entry has tag == fwd_tag. fwd_tag == ZERO_REG always gives hit = 0.
  - fwd_data = data of the youngest matching entry (closest to tail), else 0.
  - An entry that is being drained this cycle still counts as a match.
  - An entry being pushed this cycle does not count until the next cycle.
- Flush: next edge sets head = tail = 0 and count = 0. A push or drain in the flush cycle is dropped.
- Pointer wrap: index wraps DEPTH-1 → 0 and the wrap bit toggles.

## Timing
- Reset values: in_ready=0 while reset is low, 1 in the first cycle after release. wr_en=0, wr_addr=0, wr_data=0, fwd_hit=0, fwd_data=0, count=0. Pointers and storage are 0.
- Latency: a result pushed at edge N can appear on wr_en in cycle N+1 at the earliest. There is no same-cycle input-to-write bypass.
- Throughput: one push and one drain per cycle.
- count reflects the registered state and updates on the edge after a push or drain.
- Reset asserted mid-operation discards all entries asynchronously; any in-flight handshake is lost.

## Structure
- Shared package `ooo_pkg`: DATA_W, TAG_W, ZERO_REG, and `wb_entry_t` struct {tag, data}.
- One sub-module, `wb_fwd_match`: per-entry valid/tag compare plus youngest-first priority select. It is parameterised on DEPTH and takes the head/tail pointers.
- The top level holds the pointers, storage, handshake and flush logic.

## Test plan
- Reset release, push {tag 3, 0x1F} with no stall → wr_en=1, wr_addr=3, wr_data=0x1F the next cycle; count returns to 0.
- Hold wr_stall=1 and push 4 distinct entries → count=4, in_ready=0, 5th push refused. Release stall → 4 writes in FIFO order on consecutive cycles.
- Push tag 7 = 0xA, then tag 7 = 0xB, under stall; fwd_tag=7 → fwd_hit=1, fwd_data=0xB. fwd_tag=31 → hit=0.
- Push tag 31 → handshake completes, count stays 0, no wr_en.
- Six pushes with simultaneous drains over a wrap boundary → all writes in order, no duplicates or losses.
- Flush with 3 entries buffered, and separately reset low mid-drain → count=0, wr_en=0 the next cycle (immediately for reset); subsequent push works normally.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared widths, zero-register index and the buffered result entry type
// for the out-of-order writeback path.
package ooo_pkg;

    localparam int DATA_W = 64;
    localparam int TAG_W  = 5;
    localparam logic [TAG_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Forwarding lookup over the occupied window of the writeback buffer:
// per-entry tag compare with the youngest matching entry winning.
module wb_fwd_match
    import ooo_pkg::ZERO_REG;
#(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 64
) (
    input  logic [$clog2(DEPTH):0] head,
    input  logic [$clog2(DEPTH):0] tail,
    input  logic [TAG_W-1:0]       tags  [DEPTH],
    input  logic [DATA_W-1:0]      datas [DEPTH],
    input  logic [TAG_W-1:0]       fwd_tag,
    output logic                   fwd_hit,
    output logic [DATA_W-1:0]      fwd_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [TAG_W-1:0] ZERO_TAG = TAG_W'(ZERO_REG);

    logic [PW:0]   occ;
    logic [PW:0]   age;
    logic [PW-1:0] idx;

    assign occ = tail - head;

    // Walk oldest to youngest so a later (younger) match overrides an earlier one.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        age      = '0;
        idx      = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            age = CW'(k);
            idx = head[PW-1:0] + age[PW-1:0];
            if (age < occ && fwd_tag != ZERO_TAG && tags[idx] == fwd_tag) begin
                fwd_hit  = 1'b1;
                fwd_data = datas[idx];
            end
        end
    end

endmodule

// File: rtl/writeback_buffer.sv
// In-order writeback FIFO between the completion stage and the register file
// write port, with combinational forwarding of buffered results.
module writeback_buffer #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = ooo_pkg::TAG_W,
    parameter int DATA_W = ooo_pkg::DATA_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    wr_stall,
    output logic                    wr_en,
    output logic [TAG_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    input  logic [TAG_W-1:0]        fwd_tag,
    output logic                    fwd_hit,
    output logic [DATA_W-1:0]       fwd_data,
    output logic [$clog2(DEPTH):0]  count
);

    import ooo_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam logic [TAG_W-1:0] ZERO_TAG = TAG_W'(ZERO_REG);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [PW:0]        head;
    logic [PW:0]        tail;
    logic [TAG_W-1:0]   tag_mem  [DEPTH];
    logic [DATA_W-1:0]  data_mem [DEPTH];

    logic empty;
    logic full;
    logic push_fire;
    logic store;

    assign empty = (head == tail);
    assign full  = (head[PW-1:0] == tail[PW-1:0]) && (head[PW] != tail[PW]);
    assign count = tail - head;

    // Ready depends only on registered state, flush and reset, never on wr_stall.
    assign in_ready  = !full && !flush && reset;
    assign push_fire = in_valid && in_ready;
    assign store     = push_fire && (in_tag != ZERO_TAG);

    assign wr_en   = !empty && !wr_stall && !flush;
    assign wr_addr = empty ? '0 : tag_mem[head[PW-1:0]];
    assign wr_data = empty ? '0 : data_mem[head[PW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_mem[i]  <= '0;
                data_mem[i] <= '0;
            end
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (store) begin
                tag_mem[tail[PW-1:0]]  <= in_tag;
                data_mem[tail[PW-1:0]] <= in_data;
                tail                   <= tail + PTR_ONE;
            end
            if (wr_en) begin
                head <= head + PTR_ONE;
            end
        end
    end

    wb_fwd_match #(
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_fwd_match (
        .head     (head),
        .tail     (tail),
        .tags     (tag_mem),
        .datas    (data_mem),
        .fwd_tag  (fwd_tag),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
    );

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed scoreboard bench for writeback_buffer: accepted pushes queue their
// expected register writes, a negedge monitor pops and compares each write.
module tb_writeback_buffer;
    import ooo_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_tag;
    logic [63:0] in_data;
    logic        wr_stall;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  fwd_tag;
    logic        fwd_hit;
    logic [63:0] fwd_data;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    wb_entry_t exp_q[$];
    wb_entry_t mon_e;

    writeback_buffer #(
        .DEPTH  (4),
        .TAG_W  (5),
        .DATA_W (64)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_tag   (in_tag),
        .in_data  (in_data),
        .wr_stall (wr_stall),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .fwd_tag  (fwd_tag),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] t, input logic [63:0] d, input logic exp_acc);
        wb_entry_t ent;
        in_valid = 1'b1;
        in_tag   = t;
        in_data  = d;
        #1;
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_acc});
        if (exp_acc && t != 5'd31) begin
            ent.tag  = t;
            ent.data = d;
            exp_q.push_back(ent);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_fwd(input logic [4:0] t, input logic exp_hit, input logic [63:0] exp_data);
        fwd_tag = t;
        #1;
        check("fwd_hit", {63'd0, fwd_hit}, {63'd0, exp_hit});
        check("fwd_data", fwd_data, exp_data);
    endtask

    // Monitor: every register-file write must match the oldest expected entry.
    always @(negedge clk) begin
        if (wr_en) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: addr=%0d data=%0h, no write expected (t=%0t)",
                         wr_addr, wr_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (wr_addr !== mon_e.tag || wr_data !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL wr_order: got addr=%0d data=%0h, expected addr=%0d data=%0h (t=%0t)",
                             wr_addr, wr_data, mon_e.tag, mon_e.data, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_tag   = '0;
        in_data  = '0;
        wr_stall = 1'b0;
        fwd_tag  = '0;

        // Reset state
        repeat (2) tick();
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_wr_en", {63'd0, wr_en}, 64'd0);
        check("rst_wr_addr", {59'd0, wr_addr}, 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_count", {61'd0, count}, 64'd0);
        check("rst_fwd_hit", {63'd0, fwd_hit}, 64'd0);
        check("rst_fwd_data", fwd_data, 64'd0);
        reset = 1'b1;
        #1;
        check("rel_in_ready", {63'd0, in_ready}, 64'd1);

        // Single push, drains the next cycle
        push(5'd3, 64'h1F, 1'b1);
        check("single_count1", {61'd0, count}, 64'd1);
        tick();
        check("single_count0", {61'd0, count}, 64'd0);
        check("single_drained", exp_q.size(), 64'd0);

        // Fill under stall, fifth push refused, then drain in order
        wr_stall = 1'b1;
        push(5'd1, 64'h1111, 1'b1);
        push(5'd2, 64'h2222, 1'b1);
        push(5'd4, 64'h4444, 1'b1);
        push(5'd5, 64'h5555, 1'b1);
        check("full_count", {61'd0, count}, 64'd4);
        push(5'd6, 64'h6666, 1'b0);
        check("full_count_hold", {61'd0, count}, 64'd4);
        wr_stall = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            tick();
            check("drain_count", {61'd0, count}, 64'(i));
        end
        check("full_drained", exp_q.size(), 64'd0);

        // Forwarding: youngest wins, same-cycle push invisible, draining entry visible
        wr_stall = 1'b1;
        push(5'd7, 64'hA, 1'b1);
        push(5'd7, 64'hB, 1'b1);
        in_valid = 1'b1;
        in_tag   = 5'd12;
        in_data  = 64'hC;
        fwd_tag  = 5'd12;
        #1;
        check("fwd_samecycle_hit", {63'd0, fwd_hit}, 64'd0);
        mon_e.tag  = 5'd12;
        mon_e.data = 64'hC;
        exp_q.push_back(mon_e);
        tick();
        in_valid = 1'b0;
        check_fwd(5'd12, 1'b1, 64'hC);
        check_fwd(5'd7, 1'b1, 64'hB);
        check_fwd(5'd31, 1'b0, 64'd0);
        check_fwd(5'd9, 1'b0, 64'd0);
        wr_stall = 1'b0;
        check_fwd(5'd7, 1'b1, 64'hB);
        tick();
        check_fwd(5'd7, 1'b1, 64'hB);
        tick();
        check_fwd(5'd12, 1'b1, 64'hC);
        tick();
        check_fwd(5'd12, 1'b0, 64'd0);
        check("fwd_drained", exp_q.size(), 64'd0);

        // Zero register: accepted but never stored or written
        push(5'd31, 64'hDEAD, 1'b1);
        check("zero_count", {61'd0, count}, 64'd0);
        tick();
        check("zero_count2", {61'd0, count}, 64'd0);

        // Simultaneous push and drain across the pointer wrap
        wr_stall = 1'b1;
        push(5'd20, 64'h2000, 1'b1);
        push(5'd21, 64'h2100, 1'b1);
        wr_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(5'(i + 22), 64'h3000 + 64'(i), 1'b1);
            check("wrap_count", {61'd0, count}, 64'd2);
        end
        repeat (2) tick();
        check("wrap_count0", {61'd0, count}, 64'd0);
        check("wrap_drained", exp_q.size(), 64'd0);

        // Flush with three entries; push and drain in the flush cycle are dropped
        wr_stall = 1'b1;
        push(5'd1, 64'h11, 1'b1);
        push(5'd2, 64'h22, 1'b1);
        push(5'd3, 64'h33, 1'b1);
        wr_stall = 1'b0;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_tag   = 5'd13;
        in_data  = 64'h13;
        #1;
        check("flush_in_ready", {63'd0, in_ready}, 64'd0);
        check("flush_wr_en", {63'd0, wr_en}, 64'd0);
        exp_q.delete();
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_count", {61'd0, count}, 64'd0);
        check("flush_wr_en_after", {63'd0, wr_en}, 64'd0);
        push(5'd10, 64'h77, 1'b1);
        tick();
        check("flush_post_drained", exp_q.size(), 64'd0);

        // Asynchronous reset in the middle of a drain
        wr_stall = 1'b1;
        push(5'd4, 64'h44, 1'b1);
        push(5'd5, 64'h55, 1'b1);
        push(5'd6, 64'h66, 1'b1);
        wr_stall = 1'b0;
        tick();
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("arst_wr_en", {63'd0, wr_en}, 64'd0);
        check("arst_count", {61'd0, count}, 64'd0);
        check("arst_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        reset = 1'b1;
        #1;
        check("arst_rel_ready", {63'd0, in_ready}, 64'd1);
        push(5'd11, 64'h55AA, 1'b1);
        check("arst_post_count", {61'd0, count}, 64'd1);
        tick();
        check("arst_post_drained", exp_q.size(), 64'd0);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
